// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the async-FIFO read-side consumer.
//   - rd_state_t : FSM state encoding (IDLE / RUN / STOP, 2 bits)
//   - BUF_DEPTH  : depth of the output skid buffer
//   - issue_room : occupancy credit test used by the read-issue logic
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_t;

  // True when one more word may be requested: buffered words plus the word
  // already in flight, minus the word leaving this cycle, must stay below the
  // buffer depth. The pop credit is what allows one read per cycle under a
  // steady m_ready. pop is only ever asserted with occ >= 1, so the
  // subtraction cannot underflow.
  function automatic logic issue_room(input logic [1:0] occ,
                                      input logic       inflight,
                                      input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return pending < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry in-order buffer between the FIFO read port and the output stream.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   wr_en, wr_data  : capture a word at the tail
//   pop             : remove the head word
//   occ             : number of stored words (0..2)
//   head_data       : oldest stored word (held while not popped)
// The caller guarantees wr_en is never asserted when occ==2 without a pop.
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  // 1-bit pointers wrap naturally modulo 2.
  logic                  head;
  logic                  tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      // Simultaneous capture and pop leaves the occupancy unchanged.
      case ({wr_en, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
// Read-side consumer for async_FIFO, entirely in the rd_clk domain. Issues
// pops from the FIFO empty flag, absorbs the one-cycle read-data latency and
// presents the words in order on a valid/ready stream.
//
// Ports:
//   rd_clk, reset   : clock, synchronous active-high reset
//   enable          : permit new FIFO reads
//   fifo_empty      : FIFO empty flag
//   fifo_rd_data    : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en      : pop request to the FIFO (combinational)
//   m_valid/m_ready/m_data : output stream
//   idle            : FSM is in IDLE
//   rd_word_cnt     : accepted-transfer count (statistics build only)
//   stall_cnt       : back-pressure cycle count (statistics build only)
//
// Handshake: a word transfers on every rising edge where m_valid & m_ready;
// once m_valid is high, m_valid and m_data stay unchanged until that transfer.
//
// Build option: define FIFO_RD_STATS_EN to build the saturating statistics
// counters; otherwise rd_word_cnt and stall_cnt are tied to zero.
// -----------------------------------------------------------------------------
module fifo_read_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  rd_word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  rd_state_t  state_q;
  rd_state_t  state_d;
  logic       inflight_q;
  logic [1:0] occ;
  logic       pop;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign idle    = (state_q == IDLE);

  // The word requested last cycle is on fifo_rd_data now; capture it.
  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .reset     (reset),
    .wr_en     (inflight_q),
    .wr_data   (fifo_rd_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
    end
  end

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        fifo_rd_en = enable & ~fifo_empty & issue_room(occ, inflight_q, pop);
        if (!enable) state_d = STOP;
      end
      STOP: begin
        // Let the in-flight word land and the buffer drain before IDLE.
        if (enable)                              state_d = RUN;
        else if (!inflight_q && occ == 2'd0)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      rd_word_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (pop && !(&rd_word_cnt)) begin
        rd_word_cnt <= rd_word_cnt + 1'b1;
      end
      if (m_valid && !m_ready && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign rd_word_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
// Bench for fifo_read_ctrl. A queue stands in for async_FIFO (16 words,
// one-cycle read latency). Every word written into it is pushed onto exp_q;
// a monitor pops exp_q on each output transfer and compares.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int FIFO_DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic          rd_clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          idle;
  logic [CW-1:0] rd_word_cnt;
  logic [CW-1:0] stall_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_read_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .rd_clk       (rd_clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .idle         (idle),
    .rd_word_cnt  (rd_word_cnt),
    .stall_cnt    (stall_cnt)
  );

  // ---------------- reference model state ----------------
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] fifo_q[$];   // words still inside the FIFO
  logic [DW-1:0] exp_q[$];    // words owed to the output, in order
  int            pulled = 0;    // words taken from the FIFO
  int            captured = 0;  // words that have landed in the buffer
  int            accepted = 0;  // words transferred on the output
  int            pops_m = 0;
  int            stalls_m = 0;
  logic          inflight_m = 1'b0;
  logic          last_rd_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    if (fifo_q.size() < FIFO_DEPTH) begin
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive at negedge, sample fifo_rd_en just before the rising
  // edge, then play the FIFO's part after the edge.
  task automatic cycle(input logic en, input logic rdy, input logic rst);
    logic rd;
    @(negedge rd_clk);
    enable     = en;
    m_ready    = rdy;
    reset      = rst;
    fifo_empty = (fifo_q.size() == 0);
    #2;
    rd         = fifo_rd_en;
    last_rd_en = rd & ~rst;
    if (!rst && (fifo_empty || !en || idle)) check("rd_en_gated", 32'(rd), 32'd0);
    @(posedge rd_clk);
    #1;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      pulled = 0; captured = 0; accepted = 0;
      pops_m = 0; stalls_m = 0;
      inflight_m   = 1'b0;
      fifo_rd_data = DW'($urandom);
    end else begin
      captured  += int'(inflight_m);
      inflight_m = 1'b0;
      if (rd && fifo_q.size() > 0) begin
        fifo_rd_data = fifo_q.pop_front();
        pulled++;
        inflight_m = 1'b1;
      end else begin
        fifo_rd_data = DW'($urandom);
      end
      check("buffer_bound", 32'((captured - accepted + int'(inflight_m)) <= 2), 32'd1);
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic check_counters();
`ifdef FIFO_RD_STATS_EN
    check("rd_word_cnt", 32'(rd_word_cnt), 32'(pops_m));
    check("stall_cnt", 32'(stall_cnt), 32'(stalls_m));
`else
    check("rd_word_cnt_tied", 32'(rd_word_cnt), 32'd0);
    check("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif
  endtask

  task automatic check_reset_state();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_rd_word_cnt", 32'(rd_word_cnt), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_w;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge rd_clk);
      #3;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        check("m_valid_latency", 32'(m_valid), 32'(captured > accepted));
        if (prev_stall) check("m_data_hold", 32'(m_data), 32'(prev_data));
        if (idle) check("idle_drained", 32'(captured == accepted && !inflight_m), 32'd1);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got 0x%0h required no word at %0t", m_data, $time);
          end else begin
            exp_w = exp_q.pop_front();
            check("m_data", 32'(m_data), 32'(exp_w));
          end
          accepted++;
          pops_m++;
        end
        if (m_valid && !m_ready) stalls_m++;
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic seen;
    logic [DW-1:0] stream_words[7];
    stream_words = '{8'h55, 8'h22, 8'h27, 8'h33, 8'h00, 8'h77, 8'h15};

    // Reset.
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    check_reset_state();

    // Single word.
    write_word(8'hAA);
    repeat (6) cycle(1'b1, 1'b1, 1'b0);
    check("single_rd_pulses", 32'(pulled), 32'd1);
    check("single_delivered", 32'(accepted), 32'd1);
    check("single_idle_low", 32'(idle), 32'd0);

    // Stream: state is RUN, so words flow back-to-back.
    base = accepted;
    foreach (stream_words[i]) write_word(stream_words[i]);
    repeat (9) cycle(1'b1, 1'b1, 1'b0);
    check("stream_no_gaps", 32'(accepted - base), 32'd7);

    // Back-pressure with a full FIFO.
    repeat (FIFO_DEPTH) write_word(DW'($urandom));
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    check("bp_m_valid", 32'(m_valid), 32'd1);
    check("bp_rd_en", 32'(last_rd_en), 32'd0);
    check("bp_fifo_level", 32'(fifo_q.size()), 32'(FIFO_DEPTH - 2));
    repeat (22) cycle(1'b1, 1'b1, 1'b0);
    check("bp_all_out", 32'(exp_q.size()), 32'd0);
    check("bp_fifo_empty", 32'(fifo_empty), 32'd1);
    check("bp_m_valid_end", 32'(m_valid), 32'd0);
    check_counters();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) write_word(DW'($urandom));
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle(1'b1, 1'b1, 1'b0);
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check_counters();

    // Enable drop with a word in flight.
    repeat (3) write_word(DW'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      seen = last_rd_en;
    end
    check("drop_saw_rd_en", 32'(seen), 32'd1);
    cycle(1'b0, 1'b1, 1'b0);
    check("drop_not_idle_yet", 32'(idle), 32'd0);
    for (int i = 0; i < 10 && !idle; i++) cycle(1'b0, 1'b1, 1'b0);
    check("drop_idle", 32'(idle), 32'd1);
    check("drop_inflight_delivered", 32'(captured == accepted && !inflight_m), 32'd1);

    // Reset with the buffer full.
    repeat (5) write_word(DW'($urandom));
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    check("pre_reset_full", 32'(captured - accepted), 32'd2);
    cycle(1'b1, 1'b0, 1'b1);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    repeat (3) write_word(DW'($urandom));
    repeat (10) cycle(1'b1, 1'b1, 1'b0);
    check("post_reset_words", 32'(accepted), 32'd3);

    // Statistics: 10 transfers, 3 stalled cycles.
    cycle(1'b0, 1'b0, 1'b1);
    check_reset_state();
    repeat (10) write_word(DW'($urandom));
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (16) cycle(1'b1, 1'b1, 1'b0);
    check("stats_transfers", 32'(accepted), 32'd10);
`ifdef FIFO_RD_STATS_EN
    check("stats_rd_word_cnt", 32'(rd_word_cnt), 32'd10);
    check("stats_stall_cnt", 32'(stall_cnt), 32'd3);
`else
    check("stats_rd_word_cnt_off", 32'(rd_word_cnt), 32'd0);
    check("stats_stall_cnt_off", 32'(stall_cnt), 32'd0);
`endif
    check_counters();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side consumer for async_FIFO. Lives entirely in the rd_clk domain.
- Drives the FIFO's rd_en from its empty flag.
- Absorbs the FIFO's one-cycle read-data latency.
- Presents the words in order on a valid/ready stream for downstream logic.
- A 2-entry buffer gives one word per cycle under steady m_ready with no loss or duplication under back-pressure.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_data.
- CNT_WIDTH, 16, width of the statistics counters (used only with the optional feature).

Ports:
- rd_clk  in  1  read-domain clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  permit new FIFO reads.
- fifo_empty  in  1  async_FIFO empty flag.
- fifo_rd_data  in  DATA_WIDTH  async_FIFO rd_data; valid on the cycle after rd_en is sampled.
- fifo_rd_en  out  1  pop request to async_FIFO.
- m_valid  out  1  output word available.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  output word.
- idle  out  1  high in state IDLE.
- rd_word_cnt  out  CNT_WIDTH  accepted-transfer count (optional feature).
- stall_cnt  out  CNT_WIDTH  back-pressure cycle count (optional feature).

Behaviour:
- Reset values (during reset and the first cycle after): fifo_rd_en=0, m_valid=0, m_data=0, idle=1, counters=0, state=IDLE, occ=0, inflight=0.
- occ: registered occupancy counter, 0..2.
- inflight: registered flag, set when fifo_rd_en=1, cleared the next cycle when the word is written into the buffer.
- pop = m_valid & m_ready.
- Read issue rule: fifo_rd_en = (state==RUN) & enable & !fifo_empty & ((occ + inflight - pop) < 2). This is combinational; the pop credit enables full throughput.
- Latency: a word popped at edge N is captured at edge N+1 and shown on m_valid/m_data from edge N+1. Minimum latency is 1 cycle from rd_en to m_valid.
- Stream rules:
  - m_valid = (occ != 0).
  - m_data is the head entry and is held stable while m_valid & !m_ready.
  - Strict FIFO order.
  - Simultaneous capture and pop leaves occ unchanged.
- State machine:
  - IDLE -> RUN when enable=1.
  - RUN -> STOP when enable=0.
  - STOP issues no reads and waits for inflight=0 and occ=0, then -> IDLE. If enable returns to 1 during STOP, go directly to RUN.
- Boundary conditions:
  - fifo_empty=1: no rd_en. Buffered words still drain.
  - occ=2 with m_ready=0: no rd_en and no overwrite.
  - enable drop with a word in flight: that word is still captured and delivered.
  - reset mid-operation: buffered and in-flight words are discarded. The FIFO shares the same reset, so nothing is orphaned.
  - Buffer index wrap: 1-bit head/tail pointers wrap modulo 2.

Optional Feature:
- Macro FIFO_RD_STATS_EN.
- Defined:
  - rd_word_cnt increments on each pop.
  - stall_cnt increments on each cycle with m_valid & !m_ready.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports remain and are tied to 0, and no counter logic is built.

Decomposition:
- Package fifo_rd_pkg: state encodings IDLE/RUN/STOP (2-bit localparams) and BUF_DEPTH=2.
- Sub-module fifo_rd_skid: 2-entry buffer with write (capture), pop, occ, head data.
- fifo_read_ctrl holds the FSM, the issue logic and the optional counters.

Test Plan:
- Single word, 90 MHz write / 65 MHz read pair:
  - Write 0xAA, enable=1, m_ready=1.
  - Expect exactly one fifo_rd_en pulse, then m_valid with m_data=0xAA for 1 cycle, then idle remains 0 while enable=1.
- Stream:
  - Write 0x55, 0x22, 0x27, 0x33, 0x00, 0x77, 0x15.
  - With m_ready=1, m_data sequence matches exactly, with no gaps once the FIFO is non-empty.
- Back-pressure:
  - Fill FIFO to full (16 random words), m_ready=0 for 20 cycles.
  - Expect occ=2, fifo_rd_en=0, m_data stable.
  - Release m_ready: all 16 words out in order, then fifo_empty=1 and m_valid=0.
- Enable drop:
  - Deassert enable the cycle after a fifo_rd_en pulse.
  - The in-flight word is still delivered, the FSM passes through STOP, then idle=1.
- Reset mid-operation:
  - Assert reset with occ=2.
  - Next cycle: m_valid=0, m_data=0, idle=1. After reset, no stale word appears.
- FIFO_RD_STATS_EN defined:
  - 10 transfers with 3 stalled cycles give rd_word_cnt=10 and stall_cnt=3.
  - Undefined: both read 0.
